// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the transmitter that will
// reuse baud_tick_gen): receiver state encoding, frame data width and the
// clocks-per-bit helper.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_e;

   // Clock cycles per serial bit; integer division, so the baud error is
   // bounded by one clock per bit.
   function automatic int calc_baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// -----------------------------------------------------------------------------
// uart_byte_rx_if
// Parallel output bundle of the UART byte receiver.
//   rx_data   : last correctly received byte
//   rx_done   : one-cycle strobe, rx_data valid from the same cycle
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : receiver is somewhere inside a frame
// master = the receiver driving the bundle, slave = downstream consumer.
// -----------------------------------------------------------------------------
interface uart_byte_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_done;
   logic                 frame_err;
   logic                 busy;

   modport master (output rx_data, output rx_done, output frame_err, output busy);
   modport slave  (input  rx_data, input  rx_done, input  frame_err, input  busy);

endinterface

// File: rtl/uart_byte_rx_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Per-bit cycle counter for UART framing. Counts 0..BAUD_DIV-1 and wraps
// while enabled; clear has priority and forces the count to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the counter
//   en         : advance the counter
//   mid_tick   : count is at HALF_DIV-1 (middle of a start bit)
//   bit_tick   : count is at BAUD_DIV-1 (one full bit elapsed)
// -----------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int BAUD_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic mid_tick,
   output logic bit_tick
);

   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int CNT_W    = $clog2(BAUD_DIV);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_DIV - 1);

   logic [CNT_W-1:0] clk_cnt_q;
   logic [CNT_W-1:0] clk_cnt_d;

   always_comb begin
      clk_cnt_d = clk_cnt_q;
      if (clr) begin
         clk_cnt_d = '0;
      end else if (en) begin
         if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d = '0;
         end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt_q <= '0;
      end else begin
         clk_cnt_q <= clk_cnt_d;
      end
   end

   // Ticks are deliberately not gated by clr: the FSM clears the counter in
   // reaction to a tick, and gating would form a combinational loop.
   assign mid_tick = en && (clk_cnt_q == CNT_MID);
   assign bit_tick = en && (clk_cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART receiver, LSB first. Samples each bit at its centre by timing from
// the synchronized start edge; no re-synchronization inside a frame.
//   clk    : system clock (CLK_FREQ Hz)
//   rst_n  : asynchronous active-low reset
//   rxd    : raw serial line, idles high, asynchronous to clk
//   rx_if  : rx_data / rx_done / frame_err / busy (master side)
// -----------------------------------------------------------------------------
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rxd,
   uart_byte_rx_if.master rx_if
);

   localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);

   // sync_q[0] metastability stage, sync_q[1] = rxd_s, sync_q[2] = rxd_d
   logic [2:0] sync_q;
   logic [2:0] sync_d;
   logic       rxd_s;
   logic       rxd_d;
   logic       start_edge;

   rx_state_e            state_q,     state_d;
   logic [2:0]           bit_cnt_q,   bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q,     shift_d;
   logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
   logic                 rx_done_q,   rx_done_d;
   logic                 frame_err_q, frame_err_d;

   logic tick_clr;
   logic tick_en;
   logic mid_tick;
   logic bit_tick;

   assign sync_d     = {sync_q[1:0], rxd};
   assign rxd_s      = sync_q[1];
   assign rxd_d      = sync_q[2];
   assign start_edge = rxd_d & ~rxd_s;

   baud_tick_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (tick_clr),
      .en       (tick_en),
      .mid_tick (mid_tick),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      tick_clr    = 1'b0;
      tick_en     = 1'b0;

      case (state_q)
         IDLE: begin
            // Counter held at 0 so START begins counting from the edge.
            tick_clr = 1'b1;
            if (start_edge) begin
               state_d = START;
            end
         end

         START: begin
            tick_en = 1'b1;
            if (mid_tick) begin
               if (!rxd_s) begin
                  state_d   = DATA;
                  tick_clr  = 1'b1;
                  bit_cnt_d = 3'd0;
               end else begin
                  // Line was back high at mid start bit: treat as a glitch.
                  state_d = IDLE;
               end
            end
         end

         DATA: begin
            tick_en = 1'b1;
            if (bit_tick) begin
               shift_d[bit_cnt_q] = rxd_s;
               bit_cnt_d          = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end

         STOP: begin
            tick_en = 1'b1;
            if (bit_tick) begin
               if (rxd_s) begin
                  rx_data_d = shift_q;
                  rx_done_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end
         end

         WAIT_IDLE: begin
            // Break or stuck-low line: do not look for a start edge until
            // the line has been seen high again.
            tick_clr = 1'b1;
            if (rxd_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Synchronizer resets to the idle line level so release cannot
         // fabricate a start edge.
         sync_q      <= 3'b111;
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_if.rx_data   = rx_data_q;
   assign rx_if.rx_done   = rx_done_q;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.busy      = (state_q != IDLE);

endmodule
